// File: rtl/ysyx_22050133_wb_scoreboard.sv
// Writeback scoreboard: tracks in-flight producers per architectural register and
// arbitrates ALU/LSU results onto the register file's single registered write port.
module ysyx_22050133_wb_scoreboard #(
  parameter int DATA_WIDTH = 64,
  parameter int NREG       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  output logic                  iss_ready,
  input  logic [4:0]            rs1,
  output logic                  rs1_busy,
  input  logic [4:0]            rs2,
  output logic                  rs2_busy,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [5:0]            busy_cnt,
  output logic                  wb_err
);

  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  logic [NREG-1:0]       busy_r;
  logic [NREG-1:0]       busy_nxt_s;
  logic [5:0]            busy_cnt_r;
  logic                  last_grant_r;
  logic                  rf_wen_r;
  logic [4:0]            rf_rd_r;
  logic [DATA_WIDTH-1:0] rf_wdata_r;
  logic                  wb_err_r;

  logic                  alu_gnt_s;
  logic                  lsu_gnt_s;
  logic                  gnt_s;
  logic [4:0]            gnt_rd_s;
  logic [DATA_WIDTH-1:0] gnt_data_s;
  logic                  iss_fire_s;
  logic                  gnt_err_s;

  // x0 never counts as busy, so the population count skips bit 0.
  function automatic logic [5:0] popcnt(input logic [NREG-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 1; i < NREG; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  // Issue and hazard queries look only at registered busy state, never at writeback.
  assign iss_ready  = !flush && ((iss_rd == 5'd0) || !busy_r[iss_rd]);
  assign iss_fire_s = iss_valid && iss_ready && (iss_rd != 5'd0);
  assign rs1_busy   = (rs1 != 5'd0) && busy_r[rs1];
  assign rs2_busy   = (rs2 != 5'd0) && busy_r[rs2];

  // Round-robin grant: on contention, the source that did not win last time goes.
  always_comb begin
    alu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    case ({alu_valid, lsu_valid})
      2'b10:   alu_gnt_s = 1'b1;
      2'b01:   lsu_gnt_s = 1'b1;
      2'b11: begin
        if (last_grant_r == GNT_LSU) begin
          alu_gnt_s = 1'b1;
        end else begin
          lsu_gnt_s = 1'b1;
        end
      end
      default: begin
        alu_gnt_s = 1'b0;
        lsu_gnt_s = 1'b0;
      end
    endcase
  end

  assign alu_ready  = alu_gnt_s;
  assign lsu_ready  = lsu_gnt_s;
  assign gnt_s      = alu_gnt_s || lsu_gnt_s;
  assign gnt_rd_s   = alu_gnt_s ? alu_rd : lsu_rd;
  assign gnt_data_s = alu_gnt_s ? alu_data : lsu_data;
  assign gnt_err_s  = gnt_s && (gnt_rd_s != 5'd0) && !busy_r[gnt_rd_s];

  // Next busy vector: retire clears, issue sets, flush wipes everything.
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush) begin
      busy_nxt_s = '0;
    end else begin
      if (gnt_s && (gnt_rd_s != 5'd0)) begin
        busy_nxt_s[gnt_rd_s] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (iss_fire_s) begin
        busy_nxt_s[iss_rd] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // State and registered write port; a granted result lands on rf_* one cycle later.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r       <= '0;
      busy_cnt_r   <= 6'd0;
      last_grant_r <= GNT_LSU;
      rf_wen_r     <= 1'b0;
      rf_rd_r      <= 5'd0;
      rf_wdata_r   <= '0;
      wb_err_r     <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= popcnt(busy_nxt_s);
      if (gnt_s) begin
        rf_wen_r     <= (gnt_rd_s != 5'd0);
        rf_rd_r      <= gnt_rd_s;
        rf_wdata_r   <= gnt_data_s;
        last_grant_r <= lsu_gnt_s ? GNT_LSU : GNT_ALU;
      end else begin
        rf_wen_r <= 1'b0;
      end
      if (gnt_err_s) begin
        wb_err_r <= 1'b1;
      end
    end
  end

  assign rf_wen   = rf_wen_r;
  assign rf_rd    = rf_rd_r;
  assign rf_wdata = rf_wdata_r;
  assign busy_cnt = busy_cnt_r;
  assign wb_err   = wb_err_r;

endmodule

// File: tb/tb_ysyx_22050133_wb_scoreboard.sv
// Directed bench for the writeback scoreboard: hand-computed vectors checked with
// immediate assertions; inputs change 1ns after the rising edge.
module tb_ysyx_22050133_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd;
  logic [63:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_wdata;
  logic [5:0]  busy_cnt;
  logic        wb_err;

  int vectors = 0;
  int miscompares = 0;
  int n_alu = 0;
  int n_lsu = 0;
  logic exp_lsu;

  always #5 clk = ~clk;

  ysyx_22050133_wb_scoreboard #(.DATA_WIDTH(64), .NREG(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1(rs1), .rs1_busy(rs1_busy), .rs2(rs2), .rs2_busy(rs2_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd5;
    rs1 = 5'd5; rs2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 64'h0;

    // Reset held two cycles with activity on the inputs
    tick(); tick();
    check("rst_rf_wen", 64'(rf_wen), 64'd0);
    check("rst_rf_rd", 64'(rf_rd), 64'd0);
    check("rst_busy_cnt", 64'(busy_cnt), 64'd0);
    check("rst_wb_err", 64'(wb_err), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_iss_ready", 64'(iss_ready), 64'd1);
    rst = 1'b1; iss_valid = 1'b0; alu_valid = 1'b0;
    tick();
    check("idle_rf_wen", 64'(rf_wen), 64'd0);
    check("idle_busy_cnt", 64'(busy_cnt), 64'd0);
    check("idle_rs1_busy", 64'(rs1_busy), 64'd0);

    // Issue x5
    iss_valid = 1'b1; iss_rd = 5'd5; #1;
    check("iss5_ready", 64'(iss_ready), 64'd1);
    tick();
    iss_valid = 1'b0; #1;
    check("iss5_busy_cnt", 64'(busy_cnt), 64'd1);
    check("iss5_rs1_busy", 64'(rs1_busy), 64'd1);
    check("iss5_rs2_busy", 64'(rs2_busy), 64'd0);

    // Re-issue x5 blocked while ALU retires it in the same cycle
    iss_valid = 1'b1; iss_rd = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD; #1;
    check("waw_iss_ready", 64'(iss_ready), 64'd0);
    check("ret5_alu_ready", 64'(alu_ready), 64'd1);
    check("ret5_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    iss_valid = 1'b0; alu_valid = 1'b0; #1;
    check("ret5_rf_wen", 64'(rf_wen), 64'd1);
    check("ret5_rf_rd", 64'(rf_rd), 64'd5);
    check("ret5_rf_wdata", rf_wdata, 64'hDEAD);
    check("ret5_rs1_busy", 64'(rs1_busy), 64'd0);
    check("ret5_busy_cnt", 64'(busy_cnt), 64'd0);
    check("ret5_iss_ready", 64'(iss_ready), 64'd1);
    tick();
    check("hold_rf_wen", 64'(rf_wen), 64'd0);
    check("hold_rf_rd", 64'(rf_rd), 64'd5);

    // Reset pulse so last_grant returns to LSU
    rst = 1'b0; tick(); rst = 1'b1;
    iss_valid = 1'b1; iss_rd = 5'd3; tick();
    iss_rd = 5'd4; tick();
    iss_valid = 1'b0; #1;
    check("iss34_busy_cnt", 64'(busy_cnt), 64'd2);

    // Contention: ALU first, then LSU
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h22; #1;
    check("c1_alu_ready", 64'(alu_ready), 64'd1);
    check("c1_lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    check("c1_rf_rd", 64'(rf_rd), 64'd3);
    check("c1_rf_wdata", rf_wdata, 64'h11);
    check("c1_busy_cnt", 64'(busy_cnt), 64'd1);
    check("c2_alu_ready", 64'(alu_ready), 64'd0);
    check("c2_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0; #1;
    check("c2_rf_wen", 64'(rf_wen), 64'd1);
    check("c2_rf_rd", 64'(rf_rd), 64'd4);
    check("c2_rf_wdata", rf_wdata, 64'h22);
    check("c2_busy_cnt", 64'(busy_cnt), 64'd0);

    // rd==0 retire via LSU, then an unissued x7
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h99; #1;
    check("x0_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    check("x0_rf_wen", 64'(rf_wen), 64'd0);
    check("x0_wb_err", 64'(wb_err), 64'd0);
    lsu_rd = 5'd7; lsu_data = 64'h77;
    tick();
    lsu_valid = 1'b0; #1;
    check("x7_rf_wen", 64'(rf_wen), 64'd1);
    check("x7_rf_rd", 64'(rf_rd), 64'd7);
    check("x7_wb_err", 64'(wb_err), 64'd1);
    tick(); tick();
    check("x7_wb_err_sticky", 64'(wb_err), 64'd1);
    rst = 1'b0; tick(); rst = 1'b1;
    check("wb_err_cleared", 64'(wb_err), 64'd0);

    // Issue x1, x2, x9 then flush with a same-cycle retire of x1
    iss_valid = 1'b1; iss_rd = 5'd1; tick();
    iss_rd = 5'd2; tick();
    iss_rd = 5'd9; tick();
    check("iss3_busy_cnt", 64'(busy_cnt), 64'd3);
    rs1 = 5'd9; rs2 = 5'd2; #1;
    check("iss3_rs1_busy", 64'(rs1_busy), 64'd1);
    check("iss3_rs2_busy", 64'(rs2_busy), 64'd1);
    iss_rd = 5'd10; flush = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hAB; #1;
    check("flush_iss_ready", 64'(iss_ready), 64'd0);
    check("flush_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    flush = 1'b0; iss_valid = 1'b0; alu_valid = 1'b0; #1;
    check("flush_busy_cnt", 64'(busy_cnt), 64'd0);
    check("flush_rf_wen", 64'(rf_wen), 64'd1);
    check("flush_rf_rd", 64'(rf_rd), 64'd1);
    check("flush_rf_wdata", rf_wdata, 64'hAB);
    check("flush_wb_err", 64'(wb_err), 64'd0);
    check("flush_rs1_busy", 64'(rs1_busy), 64'd0);

    // Continuous contention for 10 cycles; last grant was ALU so LSU goes first
    alu_valid = 1'b1; alu_rd = 5'd11;
    lsu_valid = 1'b1; lsu_rd = 5'd12;
    for (int i = 0; i < 10; i++) begin
      alu_data = 64'hA000 + 64'(i);
      lsu_data = 64'hB000 + 64'(i);
      exp_lsu = (i % 2 == 0);
      #1;
      check("rr_alu_ready", 64'(alu_ready), 64'(!exp_lsu));
      check("rr_lsu_ready", 64'(lsu_ready), 64'(exp_lsu));
      if (alu_ready) n_alu++;
      if (lsu_ready) n_lsu++;
      tick();
      check("rr_rf_wen", 64'(rf_wen), 64'd1);
      check("rr_rf_rd", 64'(rf_rd), exp_lsu ? 64'd12 : 64'd11);
      check("rr_rf_wdata", rf_wdata, exp_lsu ? (64'hB000 + 64'(i)) : (64'hA000 + 64'(i)));
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("rr_alu_grants", 64'(n_alu), 64'd5);
    check("rr_lsu_grants", 64'(n_lsu), 64'd5);
    check("rr_wb_err", 64'(wb_err), 64'd1);
    tick();
    check("rr_end_rf_wen", 64'(rf_wen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
